// File: rtl/kl8e_tty.sv
// KL8E-compatible console teletype controller: keyboard/printer IOT
// decode, keyboard buffer and flag, printer flag, UART tx handshake.
module kl8e_tty #(
    parameter logic [5:0] KBD_DEV  = 6'o03,
    parameter logic [5:0] TTY_DEV  = 6'o04,
    parameter logic       KBD_BIT7 = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        iotStb,
    input  logic [5:0]  iotDev,
    input  logic [2:0]  iotOp,
    input  logic [11:0] acIn,
    output logic [11:0] acOut,
    output logic        acClr,
    output logic        skip,
    output logic        irq,
    output logic [7:0]  txData,
    output logic        txStb,
    input  logic        txRdy,
    input  logic [7:0]  rxData,
    input  logic        rxRdy,
    output logic        rxAck
);

    typedef enum logic [1:0] {IDLE, SEND, WAITLO, WAITHI} tx_state_e;

    tx_state_e  state_q, state_d;
    logic       kbd_flag_q, kbd_flag_d;
    logic       tty_flag_q, tty_flag_d;
    logic       queued_q, queued_d;
    logic [7:0] kbd_buf_q, kbd_buf_d;
    logic [7:0] hold_q, hold_d;
    logic       ie_q, ie_d;
    logic       rx_hist_q;
    logic       rx_ack_q;

    logic kbd_sel, tty_sel;
    logic kbd_clr, ie_wr, tty_set_iot, tty_clr, send_req;
    logic rx_arrive, tx_done;

    // Only the low byte of AC is ever transmitted or used for IE.
    logic unused_ac;
    assign unused_ac = ^acIn[11:8];

    assign rx_arrive = rxRdy & ~rx_hist_q;

    // IOT decode and combinational AC/skip response.
    always_comb begin
        acOut       = '0;
        acClr       = 1'b0;
        skip        = 1'b0;
        kbd_clr     = 1'b0;
        ie_wr       = 1'b0;
        tty_set_iot = 1'b0;
        tty_clr     = 1'b0;
        send_req    = 1'b0;
        kbd_sel     = RESET_N & iotStb & (iotDev == KBD_DEV);
        tty_sel     = RESET_N & iotStb & (iotDev == TTY_DEV);
        if (kbd_sel) begin
            case (iotOp)
                3'd0: kbd_clr = 1'b1;
                3'd1: skip = kbd_flag_q;
                3'd2: begin acClr = 1'b1; kbd_clr = 1'b1; end
                3'd4: acOut = {4'b0, kbd_buf_q};
                3'd5: ie_wr = 1'b1;
                3'd6: begin acClr = 1'b1; acOut = {4'b0, kbd_buf_q}; kbd_clr = 1'b1; end
                default: ;
            endcase
        end
        if (tty_sel) begin
            case (iotOp)
                3'd0: tty_set_iot = 1'b1;
                3'd1: skip = tty_flag_q;
                3'd2: tty_clr = 1'b1;
                3'd4: send_req = 1'b1;
                3'd5: skip = kbd_flag_q | tty_flag_q;
                3'd6: begin tty_clr = 1'b1; send_req = 1'b1; end
                default: ;
            endcase
        end
    end

    // Transmit sequencer next-state and strobe.
    always_comb begin
        state_d  = state_q;
        queued_d = queued_q;
        txStb    = 1'b0;
        tx_done  = 1'b0;
        if (send_req && state_q != IDLE) queued_d = 1'b1;
        case (state_q)
            IDLE:   if (send_req) state_d = SEND;
            SEND:   if (txRdy) begin
                        txStb   = 1'b1;
                        state_d = WAITLO;
                    end
            WAITLO: if (!txRdy) state_d = WAITHI;
            WAITHI: if (txRdy) begin
                        // A send request landing on the completion cycle counts as queued.
                        if (queued_q || send_req) begin
                            state_d  = SEND;
                            queued_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_done = 1'b1;
                        end
                    end
            default: state_d = IDLE;
        endcase
    end

    // Flag, buffer and enable next-state; hardware events override IOT clears.
    always_comb begin
        kbd_flag_d = kbd_flag_q;
        kbd_buf_d  = kbd_buf_q;
        tty_flag_d = tty_flag_q;
        hold_d     = hold_q;
        ie_d       = ie_q;
        if (kbd_clr) kbd_flag_d = 1'b0;
        if (rx_arrive) begin
            kbd_flag_d = 1'b1;
            kbd_buf_d  = {KBD_BIT7 | rxData[7], rxData[6:0]};
        end
        if (tty_set_iot) tty_flag_d = 1'b1;
        if (tty_clr)     tty_flag_d = 1'b0;
        if (tx_done)     tty_flag_d = 1'b1;
        if (send_req)    hold_d = acIn[7:0];
        if (ie_wr)       ie_d = acIn[0];
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            kbd_flag_q <= 1'b0;
            tty_flag_q <= 1'b0;
            queued_q   <= 1'b0;
            kbd_buf_q  <= '0;
            hold_q     <= '0;
            ie_q       <= 1'b1;
            rx_hist_q  <= 1'b0;
            rx_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            kbd_flag_q <= kbd_flag_d;
            tty_flag_q <= tty_flag_d;
            queued_q   <= queued_d;
            kbd_buf_q  <= kbd_buf_d;
            hold_q     <= hold_d;
            ie_q       <= ie_d;
            rx_hist_q  <= rxRdy;
            rx_ack_q   <= rx_arrive;
        end
    end

    assign irq    = ie_q & (kbd_flag_q | tty_flag_q);
    assign txData = hold_q;
    assign rxAck  = rx_ack_q;

endmodule

// File: tb/tb_kl8e_tty.sv
// Directed bench for kl8e_tty with a simple UART transmitter model.
module tb_kl8e_tty;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        iotStb = 1'b0;
    logic [5:0]  iotDev = '0;
    logic [2:0]  iotOp = '0;
    logic [11:0] acIn = '0;
    logic [11:0] acOut;
    logic        acClr, skip, irq, txStb, rxAck;
    logic [7:0]  txData;
    logic        txRdy = 1'b1;
    logic [7:0]  rxData = '0;
    logic        rxRdy = 1'b0;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    int base;
    logic [7:0] tx_log [0:15];

    kl8e_tty #(.KBD_DEV(6'o03), .TTY_DEV(6'o04), .KBD_BIT7(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .iotStb(iotStb), .iotDev(iotDev),
        .iotOp(iotOp), .acIn(acIn), .acOut(acOut), .acClr(acClr),
        .skip(skip), .irq(irq), .txData(txData), .txStb(txStb),
        .txRdy(txRdy), .rxData(rxData), .rxRdy(rxRdy), .rxAck(rxAck)
    );

    always #5 CLK = ~CLK;

    // UART tx model: drop ready one cycle after the strobe, raise it 40 cycles later.
    always begin
        @(negedge CLK);
        if (txStb === 1'b1) begin
            if (stb_cnt < 16) tx_log[stb_cnt] = txData;
            stb_cnt++;
            @(posedge CLK); #1;
            txRdy = 1'b0;
            repeat (40) @(posedge CLK);
            #1;
            txRdy = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK); #1;
    endtask

    task automatic iot_drive(input logic [5:0] dev, input logic [2:0] op, input logic [11:0] ac);
        @(negedge CLK);
        iotStb = 1'b1; iotDev = dev; iotOp = op; acIn = ac;
        #1;
    endtask

    task automatic iot_end();
        @(posedge CLK); #1;
        iotStb = 1'b0;
    endtask

    task automatic wait_irq(input int max);
        for (int i = 0; i < max; i++) begin
            if (irq === 1'b1) break;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        // Reset with rxRdy high and a KCC on the bus
        rxRdy = 1'b1; rxData = 8'h41;
        iotStb = 1'b1; iotDev = 6'o03; iotOp = 3'd2; acIn = 12'hFFF;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_acOut", acOut, 12'h000);
        check("rst_acClr", acClr, 1'b0);
        check("rst_skip", skip, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_txStb", txStb, 1'b0);
        check("rst_rxAck", rxAck, 1'b0);
        check("rst_txData", txData, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1; iotStb = 1'b0;
        cycle();
        check("post_rst_ack", rxAck, 1'b1);
        check("ie_rst_irq", irq, 1'b1);
        cycle();
        check("post_rst_ack_once", rxAck, 1'b0);
        rxRdy = 1'b0;
        cycle(); cycle();
        iot_drive(6'o03, 3'd6, 12'h000);
        check("krb0_clr", acClr, 1'b1);
        check("krb0_data", acOut, 12'o0301);
        iot_end();

        // Fresh byte 0x41
        @(negedge CLK);
        rxData = 8'h41; rxRdy = 1'b1;
        cycle();
        check("rx_ack", rxAck, 1'b1);
        cycle();
        check("rx_ack_once", rxAck, 1'b0);
        iot_drive(6'o03, 3'd1, 12'h000);
        check("ksf_set", skip, 1'b1);
        iot_end();
        iot_drive(6'o03, 3'd6, 12'h000);
        check("krb_clr", acClr, 1'b1);
        check("krb_data", acOut, 12'o0301);
        iot_end();
        iot_drive(6'o03, 3'd1, 12'h000);
        check("ksf_clear", skip, 1'b0);
        iot_end();
        rxRdy = 1'b0;

        // Single TLS
        iot_drive(6'o04, 3'd6, 12'o0215);
        iot_end();
        wait_irq(200);
        check("tls_irq", irq, 1'b1);
        check("tls_cnt", stb_cnt, 1);
        check("tls_byte", tx_log[0], 8'h8D);
        check("tls_txData", txData, 8'h8D);
        iot_drive(6'o04, 3'd1, 12'h000);
        check("tsf_set", skip, 1'b1);
        iot_end();
        iot_drive(6'o04, 3'd2, 12'h000);
        iot_end();
        check("tcf_irq", irq, 1'b0);

        // TLS then TPC while waiting for ready low
        base = stb_cnt;
        iot_drive(6'o04, 3'd6, 12'h031);
        iot_end();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK); #1;
            if (txStb === 1'b1) break;
        end
        iot_drive(6'o04, 3'd4, 12'h032);
        iot_end();
        repeat (45) cycle();
        check("q_no_early_flag", irq, 1'b0);
        check("q_second_stb", stb_cnt - base, 2);
        wait_irq(200);
        check("q_irq", irq, 1'b1);
        check("q_cnt", stb_cnt - base, 2);
        check("q_byte1", tx_log[base], 8'h31);
        check("q_byte2", tx_log[base + 1], 8'h32);
        iot_drive(6'o04, 3'd2, 12'h000);
        iot_end();
        check("q_tcf_irq", irq, 1'b0);

        // Interrupt enable
        iot_drive(6'o03, 3'd5, 12'h000);
        iot_end();
        @(negedge CLK);
        rxData = 8'h12; rxRdy = 1'b1;
        cycle();
        check("kie_ack", rxAck, 1'b1);
        cycle();
        check("kie0_irq", irq, 1'b0);
        iot_drive(6'o03, 3'd1, 12'h000);
        check("kie0_ksf", skip, 1'b1);
        iot_end();
        iot_drive(6'o04, 3'd5, 12'h000);
        check("tsk_skip", skip, 1'b1);
        iot_end();
        iot_drive(6'o03, 3'd5, 12'h001);
        check("kie1_before", irq, 1'b0);
        iot_end();
        check("kie1_irq", irq, 1'b1);

        // KCC coincident with arrival
        rxRdy = 1'b0;
        cycle();
        iot_drive(6'o03, 3'd2, 12'h000);
        rxData = 8'h55; rxRdy = 1'b1;
        #1;
        check("kcc_clr", acClr, 1'b1);
        iot_end();
        iot_drive(6'o03, 3'd1, 12'h000);
        check("kcc_flag_wins", skip, 1'b1);
        iot_end();
        iot_drive(6'o03, 3'd4, 12'h000);
        check("krs_data", acOut, 12'o0325);
        check("krs_noclr", acClr, 1'b0);
        iot_end();

        // Overrun: flag stays set, buffer overwritten
        rxRdy = 1'b0;
        cycle();
        rxData = 8'h20; rxRdy = 1'b1;
        cycle(); cycle();
        iot_drive(6'o03, 3'd4, 12'h000);
        check("ovr_data", acOut, 12'o0240);
        iot_end();
        iot_drive(6'o03, 3'd1, 12'h000);
        check("ovr_flag", skip, 1'b1);
        iot_end();

        // Unselected device
        iot_drive(6'o05, 3'd1, 12'h000);
        check("nodev_skip", skip, 1'b0);
        check("nodev_acOut", acOut, 12'h000);
        iot_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kl8e_tty.md
Name: kl8e_tty

Overview:
- Console teletype controller with KL8E-compatible IOT semantics.
- Sits between the CPU IOT bus and the UART block, and is the direct consumer of the UART's rx interface and producer for its tx interface.
- Decodes keyboard (device 03) and printer (device 04) IOTs, holds the keyboard flag/buffer and printer flag, and sequences the txStb/txRdy handshake.
- Raises the console interrupt request.

Parameters:
- KBD_DEV, 6'o03, keyboard device code.
- TTY_DEV, 6'o04, printer device code.
- KBD_BIT7, 1, when 1 the keyboard buffer bit 7 is forced to 1 on capture (PDP-8 mark parity); when 0, passed through.

Ports:
- CLK  in  1  system clock; all state on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- iotStb  in  1  one-CLK strobe; an IOT instruction is valid this cycle.
- iotDev  in  6  device field, MB[3:8].
- iotOp  in  3  operation bits, MB[9:11].
- acIn  in  12  current AC.
- acOut  out  12  data to OR into AC (after optional clear).
- acClr  out  1  CPU clears AC before ORing acOut.
- skip  out  1  CPU skips the next instruction.
- irq  out  1  interrupt request, level.
- txData  out  8  byte to UART.
- txStb  out  1  one-CLK strobe to UART.
- txRdy  in  1  UART ready.
- rxData  in  8  byte from UART.
- rxRdy  in  1  UART has a byte.
- rxAck  out  1  one-CLK acknowledge to UART.

Behaviour:
- IOT response is combinational:
  - acOut, acClr and skip are valid only while iotStb=1 and iotDev matches; otherwise all are 0.
  - State effects take place at the CLK edge ending the strobe cycle.
- Keyboard IOT table (iotDev=KBD_DEV):
  - op0 KCF: clear kbdFlag.
  - op1 KSF: skip=kbdFlag.
  - op2 KCC: acClr=1, clear kbdFlag.
  - op4 KRS: acOut={4'b0,kbdBuf}.
  - op5 KIE: ie<=acIn[0] (AC11).
  - op6 KRB: acClr=1, acOut={4'b0,kbdBuf}, clear kbdFlag.
  - Other ops: no effect.
- Printer IOT table (iotDev=TTY_DEV):
  - op0 TFL: set ttyFlag.
  - op1 TSF: skip=ttyFlag.
  - op2 TCF: clear ttyFlag.
  - op4 TPC: hold<=acIn[7:0], request send.
  - op5 TSK: skip=kbdFlag|ttyFlag.
  - op6 TLS: clear ttyFlag, hold<=acIn[7:0], request send.
- irq = ie & (kbdFlag | ttyFlag), combinational from registers.
- Receive path:
  - rxRdy rising edge, detected against a registered copy: kbdBuf<=rxData (bit7 per KBD_BIT7), set kbdFlag, rxAck=1 for exactly the next cycle.
  - Overrun (new byte while kbdFlag=1): buffer is overwritten and the flag stays 1.
  - Arrival and a flag-clearing IOT (KCF/KCC/KRB) in the same cycle: arrival wins; flag=1 and the buffer holds the new byte.
- Transmit FSM, states IDLE, SEND, WAITLO, WAITHI:
  - IDLE: on a send request go to SEND.
  - SEND: when txRdy=1, assert txStb for exactly one cycle with txData=hold, then go to WAITLO.
  - WAITLO: wait for txRdy=0, then go to WAITHI.
  - WAITHI: on txRdy=1, set ttyFlag unless queued=1; go to IDLE, or to SEND if queued (clearing queued).
  - txData always drives hold.
  - TPC/TLS while not IDLE: hold is overwritten immediately and queued<=1; one further transmission of the new hold follows. ttyFlag is set only after the final byte.
  - TFL/TCF and completion-set in the same cycle: completion-set wins.
- Reset (async, any time, including mid-transmission):
  - Registers: state=IDLE, kbdFlag=0, ttyFlag=0, queued=0, kbdBuf=0, hold=0, ie=1, rxRdy history=0.
  - Outputs: txStb=0, rxAck=0, txData=0, irq=0.
  - A partially sent UART byte is not aborted by this block.

Test Plan:
- Reset: hold RESET_N=0 with rxRdy=1 and iotStb=1 → all outputs 0, ie=1, no rxAck; after release with rxRdy already 1, rxAck still pulses once (0→1 edge from reset history).
- rxRdy 0→1 with rxData=8'h41, KBD_BIT7=1 → rxAck one cycle; KSF then gives skip=1; KRB gives acClr=1, acOut=12'o0301, and a later KSF gives skip=0.
- TLS with acIn=12'o0215, UART model dropping txRdy one cycle after strobe and raising it 10 bit-times later → exactly one txStb with txData=8'h8D; ttyFlag=1 after the rise; irq=1.
- TLS 8'h31 then TPC 8'h32 during WAITLO → two txStb pulses, second with 8'h32; ttyFlag rises only after the second completion.
- KIE with acIn=0, then a byte arrives → irq=0 with kbdFlag=1; KIE acIn=1 → irq=1 the next cycle.
- KCC coincident with an rxRdy edge (rxData=8'h55) → kbdFlag=1, KRS acOut=12'o0325.
